serial_adder_ctrl: RTL
======================

// Module: serial_adder_ctrl
//
// PURPOSE
// Bit-serial adder sequencer: drives one external 1-bit full adder (the team's `adder` cell).
// Feeds it one operand bit pair per clock, LSB first, and feeds each carry-out back as the next carry-in.
// Collects the sum bits into a WIDTH-bit result, then reports completion with a one-cycle done pulse.
// Sits directly upstream/downstream of the full adder: it produces the adder's a/b/cin and consumes its sum/cout.
//
// PARAMETERS
// WIDTH   8   operand/result width in bits; legal range 1..32
// CNT_W   5   width of the internal bit counter; must satisfy 2**CNT_W >= WIDTH
//
// PORTS
// clk      input   1      rising-edge clock
// reset    input   1      asynchronous, active-low reset
// start    input   1      request a new addition; sampled only in IDLE
// a        input   WIDTH  operand A, captured on the accepted start
// b        input   WIDTH  operand B, captured on the accepted start
// cin      input   1      initial carry-in, captured on the accepted start
// busy     output  1      1 while in RUN or DONE
// done     output  1      one-cycle completion pulse
// sum      output  WIDTH  registered result, held until the next completion
// cout     output  1      registered final carry, held until the next completion
// fa_a     output  1      to full adder input a
// fa_b     output  1      to full adder input b
// fa_cin   output  1      to full adder input cin
// fa_sum   input   1      from full adder sum output
// fa_cout  input   1      from full adder carry output
//
// BEHAVIOUR
// - Reset (reset==0, asynchronous) forces:
//   state=IDLE; busy=0, done=0, sum=0, cout=0.
//   All shift registers, carry_q and cnt cleared.
//   fa_a=fa_b=fa_cin=0.
// - Reset asserted mid-RUN aborts the operation; no done pulse is produced.
// - FSM states: IDLE, RUN, DONE.
//   - IDLE: start=1 at an edge loads a_sh<=a, b_sh<=b, carry_q<=cin, res_sh<=0, cnt<=0, and moves to RUN.
//   - RUN: on every edge, res_sh <= {fa_sum, res_sh[WIDTH-1:1]}, carry_q <= fa_cout,
//     a_sh and b_sh shift right by 1, cnt <= cnt+1.
//     When cnt==WIDTH-1 on that edge: sum <= {fa_sum, res_sh[WIDTH-1:1]}, cout <= fa_cout, go to DONE.
//   - DONE: done=1 for exactly this one cycle; next edge returns to IDLE unconditionally.
// - fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry_q while in RUN; all three are 0 in IDLE/DONE.
//   These are combinational from registers.
// - fa_sum/fa_cout are sampled at the same edge that advances the bit.
//   The full adder path must settle within one clock period.
// - Latency: start sampled at edge E.
//   RUN occupies edges E+1..E+WIDTH; done=1 during the cycle after edge E+WIDTH.
//   sum/cout are valid from that same cycle onward.
//   Next start is accepted at edge E+WIDTH+2 at the earliest.
// - start while in RUN or DONE is ignored and not queued.
//   Changes on a/b/cin after capture have no effect.
// - Arithmetic: {cout,sum} = a + b + cin, computed modulo 2**(WIDTH+1). No overflow flag.
// - sum/cout change only on completion.
//   Between operations and after an ignored start they hold the last result.
// - WIDTH==1: RUN lasts one edge; done follows in the next cycle.
//
// TESTING
// (bench instantiates serial_adder_ctrl + adder, WIDTH=8, 10 ns clock)
// 1. reset low at t=0 then released; idle 3 cycles
//    -> busy=0, done=0, sum=8'h00, cout=0, fa_*=0
// 2. a=8'h5A, b=8'h33, cin=0, start pulse
//    -> busy=1 next cycle; done=1 exactly 9 edges after start; sum=8'h8D, cout=0
// 3. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1
//    then a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1
// 4. start held high continuously with a=8'h0F, b=8'h01, cin=0
//    -> one done per 10 cycles; sum=8'h10; start pulses during RUN/DONE add no extra done
// 5. start with a=8'hAA, b=8'h55; drive reset low after 4 RUN cycles
//    -> immediately IDLE, busy=0, sum=8'h00, no done pulse
//    re-run after release -> sum=8'hFF, cout=0
// 6. change a/b/cin while busy -> result matches the captured operands
//    fa_a/fa_b sequence equals the captured bits, LSB first

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: drives an external 1-bit full adder LSB first,
// chains its carry, and assembles a WIDTH-bit sum with a one-cycle done pulse.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  // New sum bit enters at the MSB so the LSB-first stream lands in place.
  assign res_next = (res_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; full-adder drive is gated to RUN only
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    case (state)
      RUN: begin
        busy   = 1'b1;
        fa_a   = a_sh[0];
        fa_b   = b_sh[0];
        fa_cin = carry_q;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand capture, bit shifting and result latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_sh    <= a;
        b_sh    <= b;
        carry_q <= cin;
        res_sh  <= '0;
        cnt     <= '0;
      end else if (state == RUN) begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        res_sh  <= res_next;
        carry_q <= fa_cout;
        cnt     <= cnt + CNT_W'(1);
        if (last_bit) begin
          sum  <= res_next;
          cout <= fa_cout;
        end
      end
    end
  end

endmodule
